// File: rtl/ula_pkg.sv
// Shared ULA datapath definitions: operation encodings and status-flag bit positions.
package ula_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Bit positions inside a packed flag vector, for later packing into a status word.
  localparam int unsigned Z = 0;
  localparam int unsigned N = 1;
  localparam int unsigned C = 2;
  localparam int unsigned V = 3;
  localparam int unsigned NUM_FLAGS = 4;

  typedef logic [NUM_FLAGS-1:0] flags_t;

endpackage

// File: rtl/addsub_chunk_stage.sv
// One pipeline slice of the adder: resolves chunk IDX of the operands and registers the
// partial sum, the chunk carry, the remaining operand bits and a valid bit.
module addsub_chunk_stage
  import ula_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CHUNK = 4,
  parameter int unsigned IDX   = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             prev_valid,
  input  logic [WIDTH-1:0] prev_a,
  input  logic [WIDTH-1:0] prev_b,
  input  logic [WIDTH-1:0] prev_sum,
  input  logic             prev_carry,
  output logic             valid,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output flags_t           flags
);

  localparam int unsigned Lo  = IDX * CHUNK;
  localparam int unsigned Msb = Lo + CHUNK - 1;

  logic [CHUNK:0]   res;
  logic [WIDTH-1:0] a_d, b_d, sum_d;
  logic             carry_msb;
  flags_t           flags_d;

  logic             valid_q, carry_q;
  logic [WIDTH-1:0] a_q, b_q, sum_q;
  flags_t           flags_q;

  // Chunk adder; flags are only meaningful in the last slice, where sum_d is complete.
  always_comb begin
    res = {1'b0, prev_a[Lo +: CHUNK]} + {1'b0, prev_b[Lo +: CHUNK]}
        + {{CHUNK{1'b0}}, prev_carry};
    sum_d = prev_sum;
    sum_d[Lo +: CHUNK] = res[CHUNK-1:0];
    // Consumed operand chunks are dropped so later slices carry only pending bits.
    a_d = prev_a;
    a_d[Lo +: CHUNK] = '0;
    b_d = prev_b;
    b_d[Lo +: CHUNK] = '0;
    carry_msb = prev_a[Msb] ^ prev_b[Msb] ^ res[CHUNK-1];
    flags_d = '0;
    flags_d[Z] = (sum_d == '0);
    flags_d[N] = sum_d[WIDTH-1];
    flags_d[C] = res[CHUNK];
    flags_d[V] = carry_msb ^ res[CHUNK];
  end

  // Slice register: shifts on en, payload loads only for a valid beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      flags_q <= '0;
    end else if (en) begin
      valid_q <= prev_valid;
      if (prev_valid) begin
        carry_q <= res[CHUNK];
        a_q     <= a_d;
        b_q     <= b_d;
        sum_q   <= sum_d;
        flags_q <= flags_d;
      end
    end
  end

  assign valid = valid_q;
  assign a     = a_q;
  assign b     = b_q;
  assign sum   = sum_q;
  assign carry = carry_q;
  assign flags = flags_q;

endmodule

// File: rtl/addsub_pipe.sv
// Pipelined adder/subtractor: WIDTH/CHUNK chunk slices with a registered carry between
// them, NZCV flags from the final slice and valid/ready handshakes on both sides.
module addsub_pipe
  import ula_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_v
);

  localparam int unsigned STAGES = WIDTH / CHUNK;

  logic             adv;
  logic             valid_l [STAGES+1];
  logic [WIDTH-1:0] a_l     [STAGES+1];
  logic [WIDTH-1:0] b_l     [STAGES+1];
  logic [WIDTH-1:0] sum_l   [STAGES+1];
  logic             carry_l [STAGES+1];
  logic [STAGES*NUM_FLAGS-1:0] flags_flat;
  flags_t           flags_out;
  logic             unused_bits;

  // Whole pipe moves as one; a stalled output freezes every slice.
  assign adv      = out_ready || !out_valid;
  assign in_ready = adv;

  // Operand conditioning: subtraction is A + ~B + 1, Cin ignored.
  always_comb begin
    valid_l[0] = in_valid;
    a_l[0]     = A;
    sum_l[0]   = '0;
    if (sub == OP_SUB) begin
      b_l[0]     = ~B;
      carry_l[0] = 1'b1;
    end else begin
      b_l[0]     = B;
      carry_l[0] = Cin;
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    addsub_chunk_stage #(
      .WIDTH (WIDTH),
      .CHUNK (CHUNK),
      .IDX   (k)
    ) u_stage (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (adv),
      .prev_valid (valid_l[k]),
      .prev_a     (a_l[k]),
      .prev_b     (b_l[k]),
      .prev_sum   (sum_l[k]),
      .prev_carry (carry_l[k]),
      .valid      (valid_l[k+1]),
      .a          (a_l[k+1]),
      .b          (b_l[k+1]),
      .sum        (sum_l[k+1]),
      .carry      (carry_l[k+1]),
      .flags      (flags_flat[k*NUM_FLAGS +: NUM_FLAGS])
    );
  end

  assign flags_out = flags_flat[(STAGES-1)*NUM_FLAGS +: NUM_FLAGS];

  assign out_valid = valid_l[STAGES];
  assign Sum       = sum_l[STAGES];
  assign Cout      = flags_out[C];
  assign flag_z    = flags_out[Z];
  assign flag_n    = flags_out[N];
  assign flag_v    = flags_out[V];

  // Intermediate-slice flags and the drained operand/carry tails have no consumer.
  assign unused_bits = ^{flags_flat, a_l[STAGES], b_l[STAGES], carry_l[STAGES]};

endmodule
